// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP encoding and fetch-queue entry type
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus between fetch unit and imem
interface fetch_if;
  import fetch_pkg::*;
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO of fetched {instr, pc} with synchronous clear
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int AW = $clog2(QDEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  fq_entry_t wdata,
  output fq_entry_t rdata,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);
  fq_entry_t mem [QDEPTH];
  logic [AW:0] wp, rp;
  assign count = wp - rp;
  assign empty = wp == rp;
  assign full  = count == (AW+1)'(QDEPTH);
  assign rdata = mem[rp[AW-1:0]];
  // one extra pointer bit distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, variable-latency imem fetch, fetch queue and IF/ID register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] PCTargetE,
  fetch_if.master         imem,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);
  localparam int AW = $clog2(QDEPTH);
  localparam int DW = 8;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] opc [QDEPTH];
  logic [AW:0] owp, orp, outstanding, occupancy;
  logic [DW-1:0] discard;
  logic fire, drop, accept, pop, q_full, q_empty;
  fq_entry_t head, push_entry;
  assign outstanding = owp - orp;
  // credit rule: buffered plus in-flight fetches never exceed the queue depth
  assign imem.req   = rst_n && !flush && ({1'b0, occupancy} + {1'b0, outstanding} < (AW+2)'(QDEPTH));
  assign imem.addr  = pc_q;
  assign fire       = imem.req && imem.gnt;
  assign drop       = imem.rvalid && (flush || discard != '0);
  assign accept     = imem.rvalid && !drop;
  assign pop        = !flush && !stall && !q_empty;
  assign push_entry = '{instr: imem.rdata, pc: opc[orp[AW-1:0]]};
  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk, .rst_n, .push(accept), .pop, .clear(flush), .wdata(push_entry),
    .rdata(head), .full(q_full), .empty(q_empty), .count(occupancy)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      owp      <= '0;
      orp      <= '0;
      discard  <= '0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= XLEN'(4);
      ValidD   <= 1'b0;
    end else if (flush) begin
      pc_q     <= PCTargetE;
      owp      <= '0;
      orp      <= '0;
      discard  <= discard + DW'(outstanding) - DW'(imem.rvalid);
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= XLEN'(4);
      ValidD   <= 1'b0;
    end else begin
      if (fire) begin
        pc_q <= pc_q + XLEN'(4);
        owp  <= owp + (AW+1)'(1);
      end
      if (accept) orp <= orp + (AW+1)'(1);
      if (drop) discard <= discard - DW'(1);
      if (!stall) begin
        InstrD   <= pop ? head.instr : NOP_INSTR;
        PCD      <= pop ? head.pc : '0;
        PCPlus4D <= (pop ? head.pc : '0) + XLEN'(4);
        ValidD   <= pop;
      end
    end
  always_ff @(posedge clk)
    if (fire) opc[owp[AW-1:0]] <= pc_q;
  assert property (@(posedge clk) disable iff (!rst_n) !(accept && q_full));
endmodule
